// File: rtl/kiwi_perf_pkg.sv
// kiwi_perf_pkg
// Shared definitions for the kiwi top-down performance monitor:
//   perf_cnt_e  - counter select encoding used on the read port
//   NUM_CNT     - number of architecturally visible counters
//   MAX_SLOTS   - widest slot vector popcount() accepts
//   popcount()  - population count of a slot-valid vector; narrower vectors
//                 are zero-extended by the caller, which makes it width-generic
package kiwi_perf_pkg;

    typedef enum logic [2:0] {
        CYCLES   = 3'd0,
        RETIRED  = 3'd1,
        DECODED  = 3'd2,
        BUBBLE   = 3'd3,
        BACKEND  = 3'd4,
        FRONTEND = 3'd5,
        FLUSH    = 3'd6,
        BADSPEC  = 3'd7
    } perf_cnt_e;

    localparam int NUM_CNT   = 8;
    localparam int MAX_SLOTS = 8;

    function automatic logic [3:0] popcount(input logic [MAX_SLOTS-1:0] vec);
        logic [3:0] total;
        total = '0;
        for (int i = 0; i < MAX_SLOTS; i++) begin
            total = total + {3'b000, vec[i]};
        end
        return total;
    endfunction

endpackage

// File: rtl/kiwi_perf_sat_cnt.sv
// kiwi_perf_sat_cnt
// One saturating event counter with a sticky overflow flag.
// Ports:
//   clk  in   core clock
//   rst  in   synchronous active-high reset
//   clr  in   synchronous clear of count and overflow flag
//   en   in   add inc this cycle
//   inc  in   INC_W-bit increment, zero-extended to CNT_W
//   cnt  out  current count, sticks at all-ones once saturated
//   ovf  out  sticky flag, set when an increment would have wrapped
module kiwi_perf_sat_cnt
    import kiwi_perf_pkg::*;
#(
    parameter int CNT_W = 64,
    parameter int INC_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [INC_W-1:0] inc,
    output logic [CNT_W-1:0] cnt,
    output logic             ovf
);

    // One extra bit catches the carry out so saturation needs no comparator.
    logic [CNT_W:0] sum;

    assign sum = {1'b0, cnt} + {{(CNT_W + 1 - INC_W){1'b0}}, inc};

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (en) begin
            if (sum[CNT_W]) begin
                cnt <= '1;
                ovf <= 1'b1;
            end else begin
                cnt <= sum[CNT_W-1:0];
            end
        end
    end

endmodule

// File: rtl/kiwi_perf_monitor.sv
// kiwi_perf_monitor
// Top-down performance monitor for the kiwi core. Counts cycles, retired,
// decoded, bubble, frontend-bound and backend-bound slots plus flush cycles,
// freezes on the end-of-program halt and exposes every counter through a
// registered read port. BADSPEC is derived combinationally from DECODED and
// RETIRED and has no storage of its own.
// Ports:
//   clk, rst         core clock, synchronous active-high reset
//   cnt_en_i         counting enable
//   clr_i            clear counters, ovf_o and halted_o (wins over counting/halt)
//   halt_i           end-of-program seen
//   dec_vld_i        per-slot decode valid
//   backend_stall_i  backend not accepting decode this cycle
//   flush_i          pipeline flush active this cycle
//   retire_vld_i     per-slot retire valid
//   rd_en_i, rd_sel_i      read request and counter select
//   rd_data_o, rd_vld_o    read data one cycle later, with a valid pulse
//   halted_o         counting frozen by halt
//   ovf_o            sticky per-counter saturation flags
module kiwi_perf_monitor
    import kiwi_perf_pkg::*;
#(
    parameter int DECODE_W = 2,
    parameter int RETIRE_W = 2,
    parameter int CNT_W    = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cnt_en_i,
    input  logic                clr_i,
    input  logic                halt_i,
    input  logic [DECODE_W-1:0] dec_vld_i,
    input  logic                backend_stall_i,
    input  logic                flush_i,
    input  logic [RETIRE_W-1:0] retire_vld_i,
    input  logic                rd_en_i,
    input  logic [2:0]          rd_sel_i,
    output logic [CNT_W-1:0]    rd_data_o,
    output logic                rd_vld_o,
    output logic                halted_o,
    output logic [7:0]          ovf_o
);

    localparam int MAX_W   = (DECODE_W > RETIRE_W) ? DECODE_W : RETIRE_W;
    localparam int INC_W   = $clog2(MAX_W + 1);
    localparam int NUM_REG = NUM_CNT - 1;

    logic             active;
    logic [INC_W-1:0] dec_cnt;
    logic [INC_W-1:0] ret_cnt;
    logic [INC_W-1:0] inc     [NUM_REG];
    logic [CNT_W-1:0] cnt_val [NUM_REG];
    logic [NUM_REG-1:0] ovf_bits;
    logic [CNT_W-1:0] badspec;
    logic [CNT_W-1:0] rd_mux;

    assign active  = cnt_en_i & ~halted_o & ~clr_i;
    assign dec_cnt = INC_W'(popcount(MAX_SLOTS'(dec_vld_i)));
    assign ret_cnt = INC_W'(popcount(MAX_SLOTS'(retire_vld_i)));

    // Per-counter increments; every decode slot lands in exactly one of
    // DECODED's complements (BUBBLE) or its stall split (BACKEND/FRONTEND).
    always_comb begin
        inc[CYCLES]   = INC_W'(1);
        inc[RETIRED]  = ret_cnt;
        inc[DECODED]  = dec_cnt;
        inc[BUBBLE]   = INC_W'(DECODE_W) - dec_cnt;
        inc[BACKEND]  = backend_stall_i ? dec_cnt : '0;
        inc[FRONTEND] = backend_stall_i ? '0 : dec_cnt;
        inc[FLUSH]    = INC_W'(flush_i);
    end

    for (genvar g = 0; g < NUM_REG; g++) begin : g_cnt
        kiwi_perf_sat_cnt #(
            .CNT_W(CNT_W),
            .INC_W(INC_W)
        ) u_cnt (
            .clk(clk),
            .rst(rst),
            .clr(clr_i),
            .en (active),
            .inc(inc[g]),
            .cnt(cnt_val[g]),
            .ovf(ovf_bits[g])
        );
    end

    assign ovf_o = {1'b0, ovf_bits};

    // Bad speculation: slots decoded but never retired, clamped at zero.
    assign badspec = (cnt_val[DECODED] >= cnt_val[RETIRED]) ?
                     (cnt_val[DECODED] - cnt_val[RETIRED]) : '0;

    always_comb begin
        rd_mux = badspec;
        if (rd_sel_i != 3'(BADSPEC)) begin
            rd_mux = cnt_val[rd_sel_i];
        end
    end

    // Halt latches only from an active cycle, so it is ignored while disabled,
    // already halted or being cleared.
    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            halted_o <= 1'b0;
        end else if (active && halt_i) begin
            halted_o <= 1'b1;
        end
    end

    // Read port samples the pre-update counters; clr_i does not touch it so a
    // read issued with a clear returns the pre-clear value.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_vld_o  <= 1'b0;
            rd_data_o <= '0;
        end else begin
            rd_vld_o <= rd_en_i;
            if (rd_en_i) begin
                rd_data_o <= rd_mux;
            end
        end
    end

endmodule

// File: tb/tb_kiwi_perf_monitor.sv
// tb_kiwi_perf_monitor
// Scoreboard bench for kiwi_perf_monitor (DECODE_W=2, RETIRE_W=2, CNT_W=16).
// Reads push their hand-computed expected value into a queue; a monitor pops
// and compares whenever rd_vld_o is seen.
module tb_kiwi_perf_monitor;
    import kiwi_perf_pkg::*;

    localparam int CW = 16;

    typedef struct {
        logic [2:0]    sel;
        logic [CW-1:0] value;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          cnt_en_i;
    logic          clr_i;
    logic          halt_i;
    logic [1:0]    dec_vld_i;
    logic          backend_stall_i;
    logic          flush_i;
    logic [1:0]    retire_vld_i;
    logic          rd_en_i;
    logic [2:0]    rd_sel_i;
    logic [CW-1:0] rd_data_o;
    logic          rd_vld_o;
    logic          halted_o;
    logic [7:0]    ovf_o;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    kiwi_perf_monitor #(
        .DECODE_W(2),
        .RETIRE_W(2),
        .CNT_W   (CW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cnt_en_i       (cnt_en_i),
        .clr_i          (clr_i),
        .halt_i         (halt_i),
        .dec_vld_i      (dec_vld_i),
        .backend_stall_i(backend_stall_i),
        .flush_i        (flush_i),
        .retire_vld_i   (retire_vld_i),
        .rd_en_i        (rd_en_i),
        .rd_sel_i       (rd_sel_i),
        .rd_data_o      (rd_data_o),
        .rd_vld_o       (rd_vld_o),
        .halted_o       (halted_o),
        .ovf_o          (ovf_o)
    );

    always #5 clk = ~clk;

    // Watchdog so a stuck run still terminates.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Monitor: pop one expectation per read response.
    always @(negedge clk) begin
        if (rd_vld_o) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_read: actual=%0h required=no response", rd_data_o);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if (rd_data_o !== e.value) begin
                    errors++;
                    $display("[TB] FAIL read_sel%0d: actual=%0d required=%0d", e.sel, rd_data_o, e.value);
                end
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, required);
        end
    endtask

    task automatic doRead(input logic [2:0] sel, input logic [CW-1:0] value);
        exp_t e;
        e.sel   = sel;
        e.value = value;
        sb_q.push_back(e);
        rd_en_i  = 1'b1;
        rd_sel_i = sel;
        cycle();
        rd_en_i  = 1'b0;
    endtask

    task automatic applyStimulus(input logic en, input logic [1:0] dec, input logic [1:0] ret,
                                 input logic stall, input logic fl, input int n);
        cnt_en_i        = en;
        dec_vld_i       = dec;
        retire_vld_i    = ret;
        backend_stall_i = stall;
        flush_i         = fl;
        repeat (n) cycle();
        cnt_en_i        = 1'b0;
        flush_i         = 1'b0;
        backend_stall_i = 1'b0;
    endtask

    task automatic doClear();
        clr_i = 1'b1;
        cycle();
        clr_i = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cnt_en_i = 1'b0; clr_i = 1'b0; halt_i = 1'b0;
        dec_vld_i = '0; backend_stall_i = 1'b0; flush_i = 1'b0;
        retire_vld_i = '0; rd_en_i = 1'b0; rd_sel_i = '0;
        repeat (3) cycle();
        rst = 1'b0;
        cycle();
        checkOutput("reset_rd_vld", 32'(rd_vld_o), 32'd0);
        checkOutput("reset_rd_data", 32'(rd_data_o), 32'd0);
        checkOutput("reset_halted", 32'(halted_o), 32'd0);
        checkOutput("reset_ovf", 32'(ovf_o), 32'd0);

        // T1: full decode and retire, no stall, 10 cycles
        applyStimulus(1'b1, 2'b11, 2'b11, 1'b0, 1'b0, 10);
        doRead(3'(CYCLES), 16'd10);
        doRead(3'(DECODED), 16'd20);
        doRead(3'(RETIRED), 16'd20);
        doRead(3'(FRONTEND), 16'd20);
        doRead(3'(BUBBLE), 16'd0);
        doRead(3'(BACKEND), 16'd0);
        doRead(3'(BADSPEC), 16'd0);

        // T2: one slot decoded under backend stall, nothing retired
        doClear();
        applyStimulus(1'b1, 2'b01, 2'b00, 1'b1, 1'b0, 5);
        doRead(3'(BACKEND), 16'd5);
        doRead(3'(BUBBLE), 16'd5);
        doRead(3'(FRONTEND), 16'd0);
        doRead(3'(BADSPEC), 16'd5);

        // T3: halt pulse on the 4th of 8 active cycles, with flush every cycle
        doClear();
        cnt_en_i = 1'b1; dec_vld_i = 2'b11; retire_vld_i = 2'b00; flush_i = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            halt_i = (c == 4);
            cycle();
            if (c == 3) checkOutput("halted_before", 32'(halted_o), 32'd0);
            if (c == 4) checkOutput("halted_after", 32'(halted_o), 32'd1);
        end
        halt_i = 1'b0; cnt_en_i = 1'b0; flush_i = 1'b0;
        doRead(3'(CYCLES), 16'd4);
        doRead(3'(FLUSH), 16'd4);
        doRead(3'(DECODED), 16'd8);
        doRead(3'(BADSPEC), 16'd8);
        doClear();
        checkOutput("halted_cleared", 32'(halted_o), 32'd0);
        doRead(3'(CYCLES), 16'd0);
        doRead(3'(DECODED), 16'd0);

        // T4: saturation; BUBBLE (2 per cycle) saturates first, CYCLES later
        applyStimulus(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 65534);
        doRead(3'(CYCLES), 16'd65534);
        checkOutput("ovf_bubble_only", 32'(ovf_o), 32'h08);
        applyStimulus(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 3);
        doRead(3'(CYCLES), 16'hFFFF);
        doRead(3'(BUBBLE), 16'hFFFF);
        checkOutput("ovf_cycles_sat", 32'(ovf_o), 32'h09);
        doClear();
        checkOutput("ovf_cleared", 32'(ovf_o), 32'h00);

        // T5: read concurrent with increments, back-to-back
        cnt_en_i = 1'b1; dec_vld_i = 2'b10; retire_vld_i = 2'b01;
        repeat (7) cycle();
        doRead(3'(CYCLES), 16'd7);
        doRead(3'(CYCLES), 16'd8);
        cnt_en_i = 1'b0;
        doRead(3'(CYCLES), 16'd9);
        doRead(3'(RETIRED), 16'd9);

        // T6: clear, halt and flush together; read during clear sees pre-clear
        doClear();
        applyStimulus(1'b1, 2'b00, 2'b00, 1'b0, 1'b1, 2);
        cnt_en_i = 1'b1; flush_i = 1'b1; halt_i = 1'b1; clr_i = 1'b1;
        doRead(3'(FLUSH), 16'd2);
        cnt_en_i = 1'b0; flush_i = 1'b0; halt_i = 1'b0; clr_i = 1'b0;
        checkOutput("t6_halted", 32'(halted_o), 32'd0);
        doRead(3'(FLUSH), 16'd0);
        doRead(3'(CYCLES), 16'd0);

        // Reset while a read is in flight drops the response
        rd_en_i = 1'b1; rd_sel_i = 3'(CYCLES); rst = 1'b1;
        cycle();
        rd_en_i = 1'b0;
        checkOutput("rst_mid_read_vld", 32'(rd_vld_o), 32'd0);
        rst = 1'b0;
        repeat (3) cycle();
        checkOutput("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
